key_tone_synth: RTL

- Downstream consumer of the note sequencer's 8-bit key_code stream (PS/2 set-2 make codes; 8'hf0 = release/silence).
- Maps each recognised key code to a pitch and generates a square-wave tone with an attack/sustain/release envelope.
- Emits signed 16-bit audio samples to the audio codec interface stage.

---
 rtl/key_tone_synth.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/key_tone_synth.sv
// Key-code driven square-wave tone generator with an attack/sustain/release
// envelope, producing signed 16-bit samples.
module key_tone_synth #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned ENV_DIV  = 4096,
  parameter int unsigned ATT_STEP = 8,
  parameter int unsigned REL_STEP = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         key_code,
  output logic signed [15:0] audio_out,
  output logic               note_on,
  output logic [3:0]         note_idx
);

  localparam int unsigned ENV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  env_state_t         state, state_n;
  logic [7:0]         key_q, key_prev;
  logic [7:0]         amp, amp_n;
  logic [3:0]         idx_n;
  logic [23:0]        half, half_n;
  logic [23:0]        cnt, cnt_n;
  logic               phase, phase_n;
  logic [ENV_W-1:0]   env_cnt;
  logic               tick;
  logic [3:0]         key_idx;
  logic               press, release_ev;
  logic [9:0]         att_sum;
  logic signed [15:0] mag, sample_n;

  function automatic logic [3:0] code_to_idx(input logic [7:0] code);
    case (code)
      8'h2b:   code_to_idx = 4'd1;
      8'h34:   code_to_idx = 4'd2;
      8'h33:   code_to_idx = 4'd3;
      8'h3b:   code_to_idx = 4'd4;
      8'h42:   code_to_idx = 4'd5;
      8'h4b:   code_to_idx = 4'd6;
      8'h4c:   code_to_idx = 4'd7;
      8'h4a:   code_to_idx = 4'd8;
      8'h4d:   code_to_idx = 4'd9;
      8'h4e:   code_to_idx = 4'd10;
      8'h4f:   code_to_idx = 4'd11;
      8'h50:   code_to_idx = 4'd12;
      8'h51:   code_to_idx = 4'd13;
      8'h52:   code_to_idx = 4'd14;
      default: code_to_idx = 4'd0;
    endcase
  endfunction

  function automatic logic [23:0] half_of(input logic [3:0] idx);
    case (idx)
      4'd1:    half_of = 24'(CLK_HZ / (2 * 262));
      4'd2:    half_of = 24'(CLK_HZ / (2 * 294));
      4'd3:    half_of = 24'(CLK_HZ / (2 * 330));
      4'd4:    half_of = 24'(CLK_HZ / (2 * 349));
      4'd5:    half_of = 24'(CLK_HZ / (2 * 392));
      4'd6:    half_of = 24'(CLK_HZ / (2 * 440));
      4'd7:    half_of = 24'(CLK_HZ / (2 * 494));
      4'd8:    half_of = 24'(CLK_HZ / (2 * 523));
      4'd9:    half_of = 24'(CLK_HZ / (2 * 587));
      4'd10:   half_of = 24'(CLK_HZ / (2 * 659));
      4'd11:   half_of = 24'(CLK_HZ / (2 * 698));
      4'd12:   half_of = 24'(CLK_HZ / (2 * 784));
      4'd13:   half_of = 24'(CLK_HZ / (2 * 880));
      4'd14:   half_of = 24'(CLK_HZ / (2 * 988));
      default: half_of = '0;
    endcase
  endfunction

  assign tick       = (env_cnt == ENV_W'(ENV_DIV - 1));
  assign key_idx    = code_to_idx(key_q);
  assign press      = (key_idx != 4'd0) && (key_q != key_prev);
  assign release_ev = (key_idx == 4'd0) && (code_to_idx(key_prev) != 4'd0);
  assign att_sum    = 10'(amp) + 10'(ATT_STEP);

  // A key event pre-empts the envelope step that a coincident tick would make.
  always_comb begin
    state_n = state;
    amp_n   = amp;
    idx_n   = note_idx;
    half_n  = half;
    cnt_n   = cnt;
    phase_n = phase;
    if (press) begin
      state_n = ATTACK;
      idx_n   = key_idx;
      half_n  = half_of(key_idx);
      cnt_n   = '0;
      phase_n = 1'b0;
    end else begin
      if (state != IDLE) begin
        if (cnt == half - 24'd1) begin
          cnt_n   = '0;
          phase_n = ~phase;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      if (release_ev) begin
        if (state == ATTACK || state == SUSTAIN) state_n = RELEASE;
      end else if (tick) begin
        case (state)
          IDLE:    amp_n = '0;
          ATTACK: begin
            if (att_sum >= 10'd255) begin
              amp_n   = '1;
              state_n = SUSTAIN;
            end else begin
              amp_n = att_sum[7:0];
            end
          end
          SUSTAIN: amp_n = '1;
          RELEASE: begin
            if (10'(amp) <= 10'(REL_STEP)) begin
              amp_n   = '0;
              state_n = IDLE;
              idx_n   = '0;
            end else begin
              amp_n = amp - 8'(REL_STEP);
            end
          end
          default: amp_n = '0;
        endcase
      end
    end
  end

  always_comb begin
    mag      = $signed({1'b0, amp, 7'b0});
    sample_n = '0;
    if (state != IDLE) sample_n = phase ? -mag : mag;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_q     <= 8'hf0;
      key_prev  <= 8'hf0;
      amp       <= '0;
      note_idx  <= '0;
      half      <= '0;
      cnt       <= '0;
      phase     <= 1'b0;
      env_cnt   <= '0;
      audio_out <= '0;
      note_on   <= 1'b0;
    end else begin
      key_q     <= key_code;
      key_prev  <= key_q;
      amp       <= amp_n;
      note_idx  <= idx_n;
      half      <= half_n;
      cnt       <= cnt_n;
      phase     <= phase_n;
      env_cnt   <= tick ? '0 : env_cnt + ENV_W'(1);
      audio_out <= sample_n;
      note_on   <= (state != IDLE);
    end
  end

endmodule
